// File: rtl/regfile_scoreboard.sv
// 32x32 register file with write-through bypass and per-register pending-result
// counters that flag operand hazards (stall) and refuse issue when a counter is full.
module regfile_scoreboard #(
  parameter int unsigned PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_dst,
  output logic        issue_ready,
  output logic        stall,
  output logic        err_underflow
);

  localparam int unsigned NREG   = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic              err_q;
  logic              err_d;

  logic              wb_wr;
  logic              wb_dec;
  logic              wb_under;
  logic              issue_fire;
  logic              busy_rs1;
  logic              busy_rs2;
  logic [NREG-1:0]   inc_c;
  logic [NREG-1:0]   dec_c;

  // Handshake and write-back qualification; register 0 is never tracked.
  assign wb_wr       = wb_en & (wb_addr != '0);
  assign issue_ready = (pend_q[issue_dst] != PEND_MAX);
  assign issue_fire  = issue_valid & issue_ready & (issue_dst != '0);
  assign wb_dec      = wb_wr & (pend_q[wb_addr] != '0);
  assign wb_under    = wb_wr & (pend_q[wb_addr] == '0);

  // Combinational reads with zero-latency bypass of the write in flight.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1_addr != '0) rd1 = (wb_wr && (wb_addr == rs1_addr)) ? wb_data : regs_q[rs1_addr];
    if (rs2_addr != '0) rd2 = (wb_wr && (wb_addr == rs2_addr)) ? wb_data : regs_q[rs2_addr];
  end

  // A source is busy unless its last outstanding result is being written back now.
  always_comb begin
    busy_rs1 = (rs1_addr != '0) && (pend_q[rs1_addr] != '0) &&
               !(wb_en && (wb_addr == rs1_addr) && (pend_q[rs1_addr] == PEND_ONE));
    busy_rs2 = (rs2_addr != '0) && (pend_q[rs2_addr] != '0) &&
               !(wb_en && (wb_addr == rs2_addr) && (pend_q[rs2_addr] == PEND_ONE));
    stall    = busy_rs1 | busy_rs2;
  end

  // Counter next state; simultaneous issue and retire to the same register cancel.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc_c[r]  = issue_fire && (issue_dst == ADDR_W'(r));
      dec_c[r]  = wb_dec && (wb_addr == ADDR_W'(r));
      pend_d[r] = pend_q[r];
      if (inc_c[r] && !dec_c[r] && (pend_q[r] != PEND_MAX)) begin
        pend_d[r] = pend_q[r] + PEND_ONE;
      end else if (dec_c[r] && !inc_c[r] && (pend_q[r] != '0)) begin
        pend_d[r] = pend_q[r] - PEND_ONE;
      end
    end
    err_d = err_q | wb_under;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= pend_d[r];
      end
      if (wb_wr) regs_q[wb_addr] <= wb_data;
      err_q <= err_d;
    end
  end

  assign err_underflow = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, r0 handling, counter saturation,
// issue/retire collision, underflow flag and reset mid-operation.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        issue_valid;
  logic [4:0]  issue_dst;
  logic        issue_ready;
  logic        stall;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.PEND_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rd1           (rd1),
    .rd2           (rd2),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .issue_valid   (issue_valid),
    .issue_dst     (issue_dst),
    .issue_ready   (issue_ready),
    .stall         (stall),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en       = 1'b0;
    wb_addr     = 5'd0;
    wb_data     = 32'd0;
    issue_valid = 1'b0;
    issue_dst   = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rs1_addr = 5'd5;
    rs2_addr = 5'd7;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h exp %h", rd1, 32'd0); end
    checks++; if (rd2 !== 32'd0) begin errors++; $display("FAIL reset_rd2 got %h exp %h", rd2, 32'd0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", issue_ready); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_underflow); end
  endtask

  task automatic test_write_bypass();
    rs1_addr = 5'd5;
    wb_en    = 1'b1;
    wb_addr  = 5'd5;
    wb_data  = 32'hDEADBEEF;
    #1;
    checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_same_cycle got %h exp %h", rd1, 32'hDEADBEEF); end
    tick();
    idle();
    #1;
    checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_next_cycle got %h exp %h", rd1, 32'hDEADBEEF); end
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL bypass_err_on_unpended got %b exp 1", err_underflow); end
  endtask

  task automatic test_zero_reg();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rs1_addr    = 5'd0;
    rs2_addr    = 5'd0;
    wb_en       = 1'b1;
    wb_addr     = 5'd0;
    wb_data     = 32'h1234;
    issue_valid = 1'b1;
    issue_dst   = 5'd0;
    #1;
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL r0_bypass got %h exp 0", rd1); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b exp 1", issue_ready); end
    tick();
    tick();
    idle();
    #1;
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL r0_read got %h exp 0", rd1); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %b exp 0", stall); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL r0_err got %b exp 0", err_underflow); end
  endtask

  task automatic test_saturate();
    rs1_addr    = 5'd0;
    rs2_addr    = 5'd7;
    issue_valid = 1'b1;
    issue_dst   = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_ready_issue%0d got %b exp 1", i, issue_ready); end
      tick();
    end
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_ready_full got %b exp 0", issue_ready); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %b exp 1", stall); end
    tick();
    issue_valid = 1'b0;
    wb_en   = 1'b1;
    wb_addr = 5'd7;
    wb_data = 32'h0000_0111;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall_wb1 got %b exp 1", stall); end
    tick();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_ready_after_wb1 got %b exp 1", issue_ready); end
    wb_data = 32'h0000_0222;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall_wb2 got %b exp 1", stall); end
    tick();
    wb_data = 32'h0000_0333;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_stall_wb3 got %b exp 0", stall); end
    checks++; if (rd2 !== 32'h0000_0333) begin errors++; $display("FAIL sat_rd2_wb3 got %h exp %h", rd2, 32'h0000_0333); end
    tick();
    idle();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_stall_drained got %b exp 0", stall); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL sat_err got %b exp 0", err_underflow); end
  endtask

  task automatic test_back_to_back();
    rs1_addr    = 5'd9;
    rs2_addr    = 5'd0;
    issue_valid = 1'b1;
    issue_dst   = 5'd9;
    tick();
    wb_en   = 1'b1;
    wb_addr = 5'd9;
    wb_data = 32'h9999_0001;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_same got %b exp 0", stall); end
    tick();
    idle();
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall_next got %b exp 1", stall); end
    checks++; if (rd1 !== 32'h9999_0001) begin errors++; $display("FAIL b2b_rd1 got %h exp %h", rd1, 32'h9999_0001); end
    wb_en   = 1'b1;
    wb_addr = 5'd9;
    wb_data = 32'h9999_0002;
    tick();
    idle();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_drained got %b exp 0", stall); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", err_underflow); end
  endtask

  task automatic test_underflow();
    rs1_addr = 5'd3;
    wb_en    = 1'b1;
    wb_addr  = 5'd3;
    wb_data  = 32'hCAFEF00D;
    #1;
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_err_before got %b exp 0", err_underflow); end
    tick();
    idle();
    #1;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_err_set got %b exp 1", err_underflow); end
    checks++; if (rd1 !== 32'hCAFEF00D) begin errors++; $display("FAIL uf_data got %h exp %h", rd1, 32'hCAFEF00D); end
    tick();
    tick();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_err_sticky got %b exp 1", err_underflow); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL uf_stall got %b exp 0", stall); end
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1;
    issue_dst   = 5'd4;
    tick();
    issue_dst   = 5'd6;
    tick();
    issue_valid = 1'b0;
    wb_en   = 1'b1;
    wb_addr = 5'd4;
    wb_data = 32'hA5A5A5A5;
    tick();
    idle();
    rs1_addr = 5'd4;
    rs2_addr = 5'd6;
    #1;
    checks++; if (rd1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL rm_rd1_pre got %h exp %h", rd1, 32'hA5A5A5A5); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rm_stall_pre got %b exp 1", stall); end
    rst         = 1'b1;
    issue_valid = 1'b1;
    issue_dst   = 5'd6;
    wb_en       = 1'b1;
    wb_addr     = 5'd10;
    wb_data     = 32'h1010_1010;
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL rm_rd1 got %h exp 0", rd1); end
    checks++; if (rd2 !== 32'd0) begin errors++; $display("FAIL rm_rd2 got %h exp 0", rd2); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rm_stall got %b exp 0", stall); end
    issue_dst = 5'd6;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", issue_ready); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL rm_err got %b exp 0", err_underflow); end
    rs1_addr = 5'd10;
    #1;
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL rm_r10_ignored got %h exp 0", rd1); end
  endtask

  initial begin
    rst      = 1'b1;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    idle();
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_saturate();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
